// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller: default geometry,
// FSM state encoding and a small state-classification helper.
package core_ctrl_pkg;

    // Default SRAM address width, readout length and watchdog limit.
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_RD_WORDS = 16;
    localparam int DEF_TIMEOUT  = 1023;

    // FSM state encoding. Plain constants keep the encoding visible to
    // legacy tooling that does not understand enum types.
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_RD_HOLD = 3'd5;
    localparam logic [2:0] ST_FIN     = 3'd6;

    // States in which the watchdog is allowed to count.
    function automatic logic state_watched(input state_t s);
        return (s == ST_LOAD) || (s == ST_COMPUTE);
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Cycle watchdog for the controller's waiting states. The count restarts
// whenever the controller changes state and advances only while enabled.
// expire flags the cycle in which the count reaches TIMEOUT, so that the
// owning FSM can still give priority to a simultaneous exit condition.
module ctrl_watchdog
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // The counter only has to hold 0 .. TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear, otherwise advance while enabled and
    // park at the last value (the FSM leaves the state on expiry anyway).
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Cycle k after state entry holds count k; the TIMEOUT-th cycle is
    // the one holding TIMEOUT-1, and the state is left at its end.
    assign expire = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/core_ctrl.sv
// Job sequencer: loads the X buffer, runs the ALU, then streams RD_WORDS
// result words out of the SRAM through a valid/ready port. LOAD and COMPUTE
// are guarded by a watchdog that aborts the job with a sticky error.
// Every output is a flop whose next value is decoded from the next state.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_WORDS = DEF_RD_WORDS,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              xload_done,
    input  logic              ALU_done,
    output logic              input_load_en,
    output logic              ALU_en,
    output logic              rd_cs_n,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Address of the final word of a job; readout never goes past it.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RD_WORDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic              err_q;
    logic              err_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [31:0]       out_data_q;
    logic [31:0]       out_data_d;

    logic              input_load_en_q;
    logic              alu_en_q;
    logic              rd_cs_n_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    logic              wd_clear;
    logic              wd_enable;
    logic              wd_expire;

    // Watchdog restarts on every state change and runs in LOAD/COMPUTE.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = state_watched(state_q);

    ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Next-state logic: transitions, error flag, read address and the
    // captured SRAM word. Exit conditions are tested before the watchdog
    // so that a coincident exit wins over expiry.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        rd_addr_d  = rd_addr_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    err_d   = 1'b0;
                end
            end

            ST_LOAD: begin
                if (xload_done) begin
                    state_d = ST_COMPUTE;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end

            ST_COMPUTE: begin
                if (ALU_done) begin
                    state_d   = ST_RD_ISSUE;
                    rd_addr_d = '0;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end

            // Chip select is asserted for this single cycle.
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end

            // SRAM data for the issued address is present this cycle.
            ST_RD_WAIT: begin
                out_data_d = ram_rdata;
                state_d    = ST_RD_HOLD;
            end

            // Word offered; hold it until the consumer takes it.
            ST_RD_HOLD: begin
                if (out_valid_q && out_ready) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = ST_FIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = ST_RD_ISSUE;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers. Outputs are decoded from the
    // next state so each one is a flop that is valid for the whole state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            err_q           <= 1'b0;
            rd_addr_q       <= '0;
            out_data_q      <= '0;
            input_load_en_q <= 1'b0;
            alu_en_q        <= 1'b0;
            rd_cs_n_q       <= 1'b1;
            out_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            rd_addr_q       <= rd_addr_d;
            out_data_q      <= out_data_d;
            input_load_en_q <= (state_d == ST_LOAD);
            alu_en_q        <= (state_d == ST_COMPUTE);
            rd_cs_n_q       <= (state_d != ST_RD_ISSUE);
            out_valid_q     <= (state_d == ST_RD_HOLD);
            busy_q          <= (state_d != ST_IDLE);
            done_q          <= (state_d == ST_FIN);
        end
    end

    assign input_load_en = input_load_en_q;
    assign ALU_en        = alu_en_q;
    assign rd_cs_n       = rd_cs_n_q;
    assign rd_addr       = rd_addr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
